// File: rtl/sfifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// sfifo_rd_stream_if
// Signal bundle for the FIFO read-side stream adapter.
//   master modport : the adapter (drives the FIFO read request and the stream)
//   slave  modport : the FIFO + consumer side (drives empty/data, ready, flush)
// Signals:
//   fifo_rinc    read request to the FIFO
//   fifo_rempty  FIFO empty flag
//   fifo_rdata   FIFO read data, valid the cycle after an accepted read
//   m_valid      output word available
//   m_ready      consumer accepts the word
//   m_data       output word
//   flush        synchronous discard of buffered and in-flight data
//   buf_count    output buffer occupancy
// -----------------------------------------------------------------------------
interface sfifo_rd_stream_if #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 3
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic             fifo_rinc;
    logic             fifo_rempty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             flush;
    logic [CW-1:0]    buf_count;

    modport master (
        output fifo_rinc,
        input  fifo_rempty,
        input  fifo_rdata,
        output m_valid,
        input  m_ready,
        output m_data,
        input  flush,
        output buf_count
    );

    modport slave (
        input  fifo_rinc,
        output fifo_rempty,
        output fifo_rdata,
        input  m_valid,
        output m_ready,
        input  m_data,
        output flush,
        input  buf_count
    );
endinterface

// File: rtl/sfifo_rd_stream.sv
// -----------------------------------------------------------------------------
// sfifo_rd_stream
// Read-side adapter for the synchronous FIFO. Converts the FIFO pull interface
// (rinc / rempty / rdata with one cycle of registered read latency) into a
// valid/ready stream, prefetching into a small circular output buffer so the
// consumer sees one word per cycle and never deals with read latency.
// A synchronous flush discards everything buffered or still in flight.
// Ports:
//   clk  : single clock shared with the FIFO and the consumer
//   rst  : asynchronous, active-high reset
//   bus  : sfifo_rd_stream_if.master (FIFO read side + output stream + flush)
// -----------------------------------------------------------------------------
module sfifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    sfifo_rd_stream_if.master     bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);

    logic [PW-1:0]                     r_rd_ptr;
    logic [PW-1:0]                     r_wr_ptr;
    logic [CW-1:0]                     r_count;
    logic                              r_inflight;

    logic [BUF_DEPTH-1:0][WIDTH-1:0]   w_buf;
    logic [WIDTH-1:0]                  w_m_data;
    logic [CW:0]                       w_occupancy;
    logic                              w_rinc;
    logic                              w_rd_acc;
    logic                              w_land;
    logic                              w_valid;
    logic                              w_pop;

    // Circular pointer increment; depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Words already buffered plus the one possibly returning from the FIFO.
    // Requesting only while this is below the depth guarantees every landing
    // word has a free slot.
    assign w_occupancy = {1'b0, r_count} + (CW+1)'(r_inflight);

    assign w_rinc   = ~rst & ~bus.flush & ~bus.fifo_rempty
                      & (w_occupancy < (CW+1)'(BUF_DEPTH));
    assign w_rd_acc = w_rinc & ~bus.fifo_rempty;
    assign w_land   = r_inflight & ~bus.flush;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid & bus.m_ready;

    // Control state: pointers, occupancy and the in-flight marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else if (bus.flush) begin
            // A pop in this cycle is still a completed transfer; the buffer
            // simply starts over empty.
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_acc;
            if (w_land) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_land, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer entries; each captures the returning FIFO word when it is the
    // current write slot.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] r_entry;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_entry <= '0;
            end else if (w_land && (r_wr_ptr == PW'(gi))) begin
                r_entry <= bus.fifo_rdata;
            end
        end

        assign w_buf[gi] = r_entry;
    end

    // Head-of-buffer select.
    always_comb begin
        w_m_data = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (r_rd_ptr == PW'(i)) begin
                w_m_data = w_buf[i];
            end
        end
    end

    assign bus.fifo_rinc = w_rinc;
    assign bus.m_valid   = w_valid;
    assign bus.m_data    = w_m_data;
    assign bus.buf_count = r_count;

endmodule
